mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameters: none; data and address width fixed at 32.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 ex_valid  in  1  execute-stage result is valid.
REQ-006 ex_ready  out  1  stage accepts an execute result this cycle.
REQ-007 ex_alu  in  32  ALU result; the effective address for loads/stores.
REQ-008 ex_rs2  in  32  store data.
REQ-009 ex_funct3  in  3  width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 ex_rd  in  5  destination register.
REQ-011 ex_load, ex_store, ex_regwrite  in  1 each  operation class and writeback enable.
REQ-012 dmem_read, dmem_write  out  1 each  data-memory request strobes.
REQ-013 dmem_address  out  32  word-aligned address.
REQ-014 dmem_wmask  out  4  byte-lane enables for stores.
REQ-015 dmem_wdata  out  32  lane-aligned store data.
REQ-016 dmem_rdata  in  32  read data, valid with dmem_resp.
REQ-017 dmem_resp  in  1  single-cycle completion pulse.
REQ-018 wb_valid  out  1  one-cycle writeback pulse.
REQ-019 wb_rd  out  5  writeback destination.
REQ-020 wb_data  out  32  writeback value.
REQ-021 wb_regwrite  out  1  writeback enable.
REQ-022 misalign_err  out  1  qualifies wb_valid; access was misaligned.

Function
REQ-023 States: IDLE, ACCESS. ex_ready = 1 only in IDLE.
REQ-024 Accept when ex_valid & ex_ready; capture alu, rs2, funct3, rd, regwrite, load, store.
REQ-025 Non-memory op: wb_valid = 1 on the cycle after acceptance, with wb_data = ex_alu; state remains IDLE.
REQ-026 Memory op, aligned: enter ACCESS next cycle; dmem_read (load) or dmem_write (store) held high until the dmem_resp cycle inclusive; all dmem outputs stable while in ACCESS.
REQ-027 If ex_load and ex_store are both set, the op is a load.
REQ-028 dmem_address = {alu[31:2], 2'b00}; off = alu[1:0].
REQ-029 Store mask: SB 4'b0001<<off, SH 4'b0011<<off, SW 4'b1111; dmem_wdata = rs2 << (8*off). Loads drive dmem_wmask = 0.
REQ-030 Misalignment: H/HU with off = 3, or W with off != 0 -> no memory request; wb_valid the cycle after acceptance with misalign_err = 1 and wb_regwrite = 0.
REQ-031 On dmem_resp in ACCESS, return to IDLE; wb_valid = 1 on the next cycle. Minimum load/store latency is acceptance to wb_valid = 2 cycles plus the memory wait.
REQ-032 Load data: byte = rdata[8*off+:8], half = rdata[8*off+:16], both sign-extended for B/H and zero-extended for BU/HU; W = rdata. Store: wb_regwrite = 0, wb_data = alu.
REQ-033 wb_rd = captured rd; wb_regwrite = captured regwrite, except that it is forced to 0 for stores and misaligned accesses.
REQ-034 dmem_resp in IDLE is ignored.
REQ-035 No new op is accepted in the dmem_resp cycle; ex_ready rises the following cycle, so back-to-back memory ops are spaced by at least one cycle.
REQ-036 wb_valid, misalign_err: single-cycle pulses; wb_data, wb_rd, wb_regwrite hold their values until the next pulse.

Reset
REQ-037 On rst high, immediately (asynchronously): state IDLE; dmem_read, dmem_write, wb_valid, wb_regwrite, misalign_err = 0; dmem_wmask = 0; dmem_address, dmem_wdata, wb_data = 0; wb_rd = 0.
REQ-038 Reset during ACCESS abandons the request; a dmem_resp arriving after reset release is ignored (REQ-034).
REQ-039 ex_ready = 1 in the first cycle after reset deassertion.

Verification
REQ-040 ALU op: ex_alu = 0x1234, rd = 5, regwrite = 1 -> next cycle wb_valid = 1, wb_data = 0x1234, wb_rd = 5; no dmem strobe.
REQ-041 LB at 0x1003, rdata = 0x80FF_FFFF, resp after 3 cycles -> dmem_address 0x1000, dmem_read held 3 cycles, wb_data = 0xFFFF_FF80.
REQ-042 SH at 0x2002, rs2 = 0xABCD -> dmem_wmask 4'b1100, dmem_wdata 0xABCD_0000, wb_regwrite = 0.
REQ-043 LW at 0x3001 -> no dmem_read; wb_valid with misalign_err = 1, wb_regwrite = 0.
REQ-044 Assert rst mid-ACCESS, then pulse dmem_resp after release -> dmem_read drops immediately, no wb_valid, ex_ready = 1.
REQ-045 Two back-to-back LBU ops with ex_valid held -> the second is accepted only after the first's wb cycle; both results are correct and zero-extended.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: takes one execute result at a time, issues an
// aligned data-memory request for loads/stores, and produces a one-cycle
// writeback pulse with the (extended) load value or the ALU result.
//
// Handshake: an execute result transfers on a rising edge where
// ex_valid && ex_ready. ex_ready is high only while the stage is idle; the
// producer must hold its fields stable until that edge. The memory side is
// not back-pressured: dmem_read/dmem_write stay high, with address, mask and
// data frozen, until the single-cycle dmem_resp pulse arrives.
module mem_access_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_alu,
  input  logic [31:0] ex_rs2,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic        ex_regwrite,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_regwrite,
  output logic        misalign_err
);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e      state_q, state_d;
  logic [31:0] alu_q, alu_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic        regwrite_q, regwrite_d;
  logic        load_q, load_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic        misalign_q, misalign_d;

  logic [1:0]  off;
  logic        accept, is_load, is_store, is_mem, misaligned;
  logic [3:0]  store_mask;
  logic [31:0] rshift, load_val;

  assign ex_ready     = (state_q == IDLE);
  assign dmem_read    = read_q;
  assign dmem_write   = write_q;
  assign dmem_address = addr_q;
  assign dmem_wmask   = wmask_q;
  assign dmem_wdata   = wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign wb_regwrite  = wb_regwrite_q;
  assign misalign_err = misalign_q;

  // Decode of the incoming execute result: class, alignment and store lanes.
  always_comb begin
    off        = ex_alu[1:0];
    accept     = ex_valid & ex_ready;
    is_load    = ex_load;                 // load wins if both flags are set
    is_store   = ex_store & ~ex_load;
    is_mem     = is_load | is_store;
    misaligned = is_mem &
                 (((ex_funct3[1:0] == 2'b01) && (off == 2'd3)) ||
                  (ex_funct3[1] && (off != 2'd0)));
    case (ex_funct3[1:0])
      2'b00:   store_mask = 4'b0001 << off;
      2'b01:   store_mask = 4'b0011 << off;
      default: store_mask = 4'b1111;
    endcase
  end

  // Lane selection and sign/zero extension of the returned read word.
  always_comb begin
    rshift = dmem_rdata >> {alu_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_val = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  load_val = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  load_val = {24'd0, rshift[7:0]};
      3'b101:  load_val = {16'd0, rshift[15:0]};
      default: load_val = dmem_rdata;
    endcase
  end

  // Next-state and next-output logic for the IDLE/ACCESS controller.
  always_comb begin
    state_d       = state_q;
    alu_d         = alu_q;
    funct3_d      = funct3_q;
    rd_d          = rd_q;
    regwrite_d    = regwrite_q;
    load_d        = load_q;
    read_d        = read_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wmask_d       = wmask_q;
    wdata_d       = wdata_q;
    wb_valid_d    = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    wb_regwrite_d = wb_regwrite_q;
    misalign_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          alu_d      = ex_alu;
          funct3_d   = ex_funct3;
          rd_d       = ex_rd;
          regwrite_d = ex_regwrite;
          load_d     = is_load;
          if (!is_mem || misaligned) begin
            // Completes without touching memory: writeback next cycle.
            wb_valid_d    = 1'b1;
            wb_data_d     = ex_alu;
            wb_rd_d       = ex_rd;
            wb_regwrite_d = ex_regwrite & ~is_mem;
            misalign_d    = misaligned;
          end else begin
            state_d = ACCESS;
            read_d  = is_load;
            write_d = is_store;
            addr_d  = {ex_alu[31:2], 2'b00};
            wmask_d = is_store ? store_mask : 4'b0000;
            wdata_d = is_store ? (ex_rs2 << {off, 3'b000}) : 32'd0;
          end
        end
      end
      ACCESS: begin
        if (dmem_resp) begin
          state_d       = IDLE;
          read_d        = 1'b0;
          write_d       = 1'b0;
          wb_valid_d    = 1'b1;
          wb_rd_d       = rd_q;
          wb_data_d     = load_q ? load_val : alu_q;
          wb_regwrite_d = regwrite_q & load_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any outstanding request at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      alu_q         <= 32'd0;
      funct3_q      <= 3'd0;
      rd_q          <= 5'd0;
      regwrite_q    <= 1'b0;
      load_q        <= 1'b0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      addr_q        <= 32'd0;
      wmask_q       <= 4'd0;
      wdata_q       <= 32'd0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_data_q     <= 32'd0;
      wb_regwrite_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      alu_q         <= alu_d;
      funct3_q      <= funct3_d;
      rd_q          <= rd_d;
      regwrite_q    <= regwrite_d;
      load_q        <= load_d;
      read_q        <= read_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wmask_q       <= wmask_d;
      wdata_q       <= wdata_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      wb_regwrite_q <= wb_regwrite_d;
      misalign_q    <= misalign_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: a table of single operations with hand-computed
// results, followed by hand-written reset and back-to-back sequences.
module tb_mem_access_stage;

  logic        clk, rst;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_alu, ex_rs2;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_load, ex_store, ex_regwrite;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_address, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wmask;
  logic        dmem_resp;
  logic        wb_valid, wb_regwrite, misalign_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu(ex_alu), .ex_rs2(ex_rs2), .ex_funct3(ex_funct3), .ex_rd(ex_rd),
    .ex_load(ex_load), .ex_store(ex_store), .ex_regwrite(ex_regwrite),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_regwrite(wb_regwrite), .misalign_err(misalign_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cur     = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL v%0d %s: got %h expected %h", cur, name, act, exp);
    end
  endtask

  // kind: 0 = no memory request, 1 = read, 2 = write
  typedef struct {
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        ld, st, rw;
    logic [31:0] rdata;
    int          delay;
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] wbd;
    logic        wrw;
    logic        mis;
  } vec_t;

  function automatic vec_t mk(
    input logic [31:0] alu, input logic [31:0] rs2, input logic [2:0] f3,
    input logic [4:0] rd, input logic ld, input logic st, input logic rw,
    input logic [31:0] rdata, input int delay, input logic [1:0] kind,
    input logic [31:0] addr, input logic [3:0] wmask, input logic [31:0] wdata,
    input logic [31:0] wbd, input logic wrw, input logic mis);
    vec_t v;
    v.alu = alu; v.rs2 = rs2; v.f3 = f3; v.rd = rd; v.ld = ld; v.st = st;
    v.rw = rw; v.rdata = rdata; v.delay = delay; v.kind = kind; v.addr = addr;
    v.wmask = wmask; v.wdata = wdata; v.wbd = wbd; v.wrw = wrw; v.mis = mis;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    ex_valid = 1'b0; ex_alu = '0; ex_rs2 = '0; ex_funct3 = '0; ex_rd = '0;
    ex_load = 1'b0; ex_store = 1'b0; ex_regwrite = 1'b0;
    dmem_resp = 1'b0; dmem_rdata = '0;
  endtask

  task automatic check_wb(input vec_t v);
    chk("wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("wb_data", wb_data, exp_q.pop_front());
    chk("wb_rd", {27'd0, wb_rd}, {27'd0, v.rd});
    chk("wb_regwrite", {31'd0, wb_regwrite}, {31'd0, v.wrw});
    chk("misalign_err", {31'd0, misalign_err}, {31'd0, v.mis});
    chk("strobes_after", {30'd0, dmem_read, dmem_write}, 32'd0);
    @(posedge clk); #1;
    chk("wb_valid_pulse", {31'd0, wb_valid}, 32'd0);
    chk("misalign_pulse", {31'd0, misalign_err}, 32'd0);
    chk("wb_data_hold", wb_data, v.wbd);
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk("ex_ready_idle", {31'd0, ex_ready}, 32'd1);
    ex_valid = 1'b1; ex_alu = v.alu; ex_rs2 = v.rs2; ex_funct3 = v.f3;
    ex_rd = v.rd; ex_load = v.ld; ex_store = v.st; ex_regwrite = v.rw;
    dmem_rdata = 32'hA5A5_5A5A;
    exp_q.push_back(v.wbd);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    if (v.kind != 2'd0) begin
      for (int k = 1; k <= v.delay; k++) begin
        chk("dmem_read", {31'd0, dmem_read}, {31'd0, v.kind == 2'd1});
        chk("dmem_write", {31'd0, dmem_write}, {31'd0, v.kind == 2'd2});
        chk("dmem_address", dmem_address, v.addr);
        chk("dmem_wmask", {28'd0, dmem_wmask}, {28'd0, v.wmask});
        if (v.kind == 2'd2) chk("dmem_wdata", dmem_wdata, v.wdata);
        chk("ex_ready_busy", {31'd0, ex_ready}, 32'd0);
        chk("wb_valid_busy", {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        if (k == v.delay) begin
          dmem_resp = 1'b1;
          dmem_rdata = v.rdata;
        end
        @(posedge clk); #1;
        dmem_resp = 1'b0;
      end
    end
    check_wb(v);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[$];

  initial begin
    //                alu           rs2           f3     rd  ld st rw rdata         dly kind addr          wmask    wdata         wbd           wrw mis
    vecs.push_back(mk(32'h0000_1234, 32'h0,        3'b010, 5,  0, 0, 1, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0000_1234, 1, 0));
    vecs.push_back(mk(32'hFFFF_0000, 32'h0,        3'b010, 31, 0, 0, 0, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'hFFFF_0000, 0, 0));
    vecs.push_back(mk(32'h0000_1003, 32'h1,        3'b000, 3,  1, 0, 1, 32'h80FF_FFFF, 3, 1, 32'h0000_1000, 4'b0000, 32'h0,        32'hFFFF_FF80, 1, 0));
    vecs.push_back(mk(32'h0000_2002, 32'h0000_ABCD, 3'b001, 4,  0, 1, 1, 32'h0,        1, 2, 32'h0000_2000, 4'b1100, 32'hABCD_0000, 32'h0000_2002, 0, 0));
    vecs.push_back(mk(32'h0000_3001, 32'h0,        3'b010, 6,  1, 0, 1, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0000_3001, 0, 1));
    vecs.push_back(mk(32'h0000_1001, 32'h0,        3'b100, 7,  1, 0, 1, 32'h1234_80AB, 1, 1, 32'h0000_1000, 4'b0000, 32'h0,        32'h0000_0080, 1, 0));
    vecs.push_back(mk(32'h0000_4002, 32'h0,        3'b001, 8,  1, 0, 1, 32'h8001_0000, 2, 1, 32'h0000_4000, 4'b0000, 32'h0,        32'hFFFF_8001, 1, 0));
    vecs.push_back(mk(32'h0000_4000, 32'h0,        3'b101, 9,  1, 0, 1, 32'h0000_F00D, 1, 1, 32'h0000_4000, 4'b0000, 32'h0,        32'h0000_F00D, 1, 0));
    vecs.push_back(mk(32'h0000_5000, 32'h0,        3'b010, 10, 1, 0, 1, 32'hDEAD_BEEF, 1, 1, 32'h0000_5000, 4'b0000, 32'h0,        32'hDEAD_BEEF, 1, 0));
    vecs.push_back(mk(32'h0000_6003, 32'h1122_3344, 3'b000, 11, 0, 1, 1, 32'h0,        2, 2, 32'h0000_6000, 4'b1000, 32'h4400_0000, 32'h0000_6003, 0, 0));
    vecs.push_back(mk(32'h0000_7000, 32'hCAFE_BABE, 3'b010, 12, 0, 1, 0, 32'h0,        1, 2, 32'h0000_7000, 4'b1111, 32'hCAFE_BABE, 32'h0000_7000, 0, 0));
    vecs.push_back(mk(32'h0000_8003, 32'h5555,     3'b001, 13, 0, 1, 1, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0000_8003, 0, 1));
    vecs.push_back(mk(32'h0000_8007, 32'h0,        3'b101, 14, 1, 0, 1, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0000_8007, 0, 1));
    vecs.push_back(mk(32'h0000_9004, 32'h7777,     3'b010, 15, 1, 1, 1, 32'h0BAD_F00D, 1, 1, 32'h0000_9004, 4'b0000, 32'h0,        32'h0BAD_F00D, 1, 0));
    vecs.push_back(mk(32'h0000_A002, 32'h1234,     3'b010, 16, 0, 1, 1, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0000_A002, 0, 1));
    vecs.push_back(mk(32'h0000_B001, 32'h0,        3'b001, 17, 1, 0, 1, 32'h00AB_CD00, 1, 1, 32'h0000_B000, 4'b0000, 32'h0,        32'hFFFF_ABCD, 1, 0));

    // Reset values while reset is held, then ready right after release.
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
    chk("rst_wb_flags", {29'd0, wb_valid, wb_regwrite, misalign_err}, 32'd0);
    chk("rst_addr", dmem_address, 32'd0);
    chk("rst_wmask", {28'd0, dmem_wmask}, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ex_ready_after_rst", {31'd0, ex_ready}, 32'd1);

    // Table-driven single operations.
    for (int i = 0; i < vecs.size(); i++) begin
      cur = i;
      run_vec(vecs[i]);
    end

    // Reset in the middle of an access abandons it; a late resp is ignored.
    cur = 100;
    @(negedge clk);
    ex_valid = 1'b1; ex_alu = 32'h0000_1003; ex_funct3 = 3'b000; ex_rd = 5'd3;
    ex_load = 1'b1; ex_store = 1'b0; ex_regwrite = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("rst_mid_read_before", {31'd0, dmem_read}, 32'd1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_read_drop", {31'd0, dmem_read}, 32'd0);
    chk("rst_mid_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_mid_addr", dmem_address, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    dmem_resp = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("late_resp_no_wb", {31'd0, wb_valid}, 32'd0);
      chk("late_resp_no_read", {31'd0, dmem_read}, 32'd0);
      chk("late_resp_ready", {31'd0, ex_ready}, 32'd1);
      @(posedge clk); #1;
    end

    // Two LBU ops with ex_valid held: second accepted only after first wb.
    cur = 200;
    @(negedge clk);
    ex_valid = 1'b1; ex_alu = 32'h0000_1002; ex_funct3 = 3'b100; ex_rd = 5'd7;
    ex_load = 1'b1; ex_store = 1'b0; ex_regwrite = 1'b1;
    @(posedge clk); #1;
    chk("b2b_read1", {31'd0, dmem_read}, 32'd1);
    chk("b2b_addr1", dmem_address, 32'h0000_1000);
    ex_alu = 32'h0000_2001; ex_rd = 5'd8;
    @(posedge clk); #1;
    chk("b2b_wait_ready", {31'd0, ex_ready}, 32'd0);
    chk("b2b_wait_addr", dmem_address, 32'h0000_1000);
    @(negedge clk);
    dmem_resp = 1'b1; dmem_rdata = 32'h00AB_0000;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    chk("b2b_wb1_valid", {31'd0, wb_valid}, 32'd1);
    chk("b2b_wb1_data", wb_data, 32'h0000_00AB);
    chk("b2b_wb1_rd", {27'd0, wb_rd}, 32'd7);
    chk("b2b_wb1_no_read", {31'd0, dmem_read}, 32'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("b2b_read2", {31'd0, dmem_read}, 32'd1);
    chk("b2b_addr2", dmem_address, 32'h0000_2000);
    chk("b2b_wb_gap", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    dmem_resp = 1'b1; dmem_rdata = 32'h0000_9900;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    chk("b2b_wb2_valid", {31'd0, wb_valid}, 32'd1);
    chk("b2b_wb2_data", wb_data, 32'h0000_0099);
    chk("b2b_wb2_rd", {27'd0, wb_rd}, 32'd8);
    chk("b2b_wb2_rw", {31'd0, wb_regwrite}, 32'd1);

    // Back-to-back ALU ops complete on consecutive cycles.
    cur = 300;
    @(negedge clk);
    ex_valid = 1'b1; ex_alu = 32'h0000_0011; ex_rd = 5'd1;
    ex_load = 1'b0; ex_store = 1'b0; ex_regwrite = 1'b1;
    @(posedge clk); #1;
    chk("alu_b2b_wb1", wb_data, 32'h0000_0011);
    ex_alu = 32'h0000_0022; ex_rd = 5'd2;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("alu_b2b_valid2", {31'd0, wb_valid}, 32'd1);
    chk("alu_b2b_wb2", wb_data, 32'h0000_0022);
    chk("alu_b2b_rd2", {27'd0, wb_rd}, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
